pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: Pipeline_Controller

Interface
REQ-001 Parameter TIMEOUT, 255, max MEM_WAIT cycles before ERROR (range 1..255).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 IDEX_MemRead_i  input  1  instruction in EX is a load.
REQ-005 IDEX_Rd_i  input  5  destination register of instruction in EX.
REQ-006 IFID_Rs1_i  input  5  rs1 of instruction in ID.
REQ-007 IFID_Rs2_i  input  5  rs2 of instruction in ID.
REQ-008 Branch_i  input  1  branch in ID resolved taken.
REQ-009 MemAccess_i  input  1  instruction in MEM performs a load/store.
REQ-010 mem_ack_i  input  1  data memory completes the access this cycle.
REQ-011 PCWrite_o  output  1  PC register update enable.
REQ-012 IFID_Write_o  output  1  IF/ID register update enable.
REQ-013 NoOp_o  output  1  insert bubble into ID/EX (control fields zeroed).
REQ-014 Flush_o  output  1  clear IF/ID (squash fetched instruction).
REQ-015 Stall_o  output  1  freeze ID/EX, EX/MEM, MEM/WB registers.
REQ-016 mem_req_o  output  1  data-memory request strobe.
REQ-017 err_o  output  1  memory timeout, sticky.
REQ-018 stall_cnt_o  output  16  count of cycles with PCWrite_o=0 since reset.

Function
REQ-019 States SHALL be RUN, MEM_WAIT, ERROR, held in a registered state variable; all outputs except stall_cnt_o and err_o combinational from state and inputs.
REQ-020 Load-use hazard (LU) SHALL be IDEX_MemRead_i=1, IDEX_Rd_i!=0, and IDEX_Rd_i equal to IFID_Rs1_i or IFID_Rs2_i.
REQ-021 RUN, MemAccess_i=1, mem_ack_i=0: mem_req_o=1, Stall_o=1, PCWrite_o=0, IFID_Write_o=0, NoOp_o=0, Flush_o=0; next state MEM_WAIT.
REQ-022 RUN, MemAccess_i=1, mem_ack_i=1: zero-wait access; mem_req_o=1, no stall from memory; remain RUN; LU/branch rules apply.
REQ-023 RUN, no memory stall, LU=1: PCWrite_o=0, IFID_Write_o=0, NoOp_o=1, Flush_o=0 (branch suppressed, re-evaluated next cycle).
REQ-024 RUN, no memory stall, LU=0, Branch_i=1: Flush_o=1, PCWrite_o=1, IFID_Write_o=1, NoOp_o=0.
REQ-025 RUN, no stall, no branch: PCWrite_o=1, IFID_Write_o=1, NoOp_o=0, Flush_o=0, Stall_o=0, mem_req_o=MemAccess_i.
REQ-026 MEM_WAIT: mem_req_o=1, Stall_o=1, PCWrite_o=0, IFID_Write_o=0, NoOp_o=0, Flush_o=0 regardless of LU/Branch_i.
REQ-027 MEM_WAIT, mem_ack_i=1: outputs still frozen that cycle; next state RUN; wait counter cleared.
REQ-028 MEM_WAIT SHALL count cycles in 8-bit counter; if mem_ack_i=0 when counter reaches TIMEOUT-1, next state ERROR.
REQ-029 ERROR: err_o=1, Stall_o=1, PCWrite_o=0, IFID_Write_o=0, mem_req_o=0, NoOp_o=0, Flush_o=0; exit only via rst_i.
REQ-030 stall_cnt_o SHALL increment each cycle PCWrite_o=0 (rst_i low), saturating at 16'hFFFF.

Reset
REQ-031 rst_i=1 at clock edge: state RUN, wait counter 0, err_o 0, stall_cnt_o 0.
REQ-032 While rst_i=1: PCWrite_o=0, IFID_Write_o=0, NoOp_o=1, Flush_o=0, Stall_o=0, mem_req_o=0; stall_cnt_o not incremented.
REQ-033 rst_i asserted mid-MEM_WAIT or in ERROR SHALL return to RUN on that edge, abandoning the access.

Verification
REQ-034 LU: IDEX_MemRead_i=1, IDEX_Rd_i=5, IFID_Rs2_i=5 for one cycle -> PCWrite_o=0, IFID_Write_o=0, NoOp_o=1; stall_cnt_o 0->1.
REQ-035 Rd zero: IDEX_MemRead_i=1, IDEX_Rd_i=0, IFID_Rs1_i=0 -> no stall, PCWrite_o=1.
REQ-036 LU + Branch_i=1 same cycle -> Flush_o=0, NoOp_o=1; next cycle LU cleared, Branch_i=1 -> Flush_o=1.
REQ-037 MemAccess_i=1, mem_ack_i low 3 cycles then high -> Stall_o=1 for 4 cycles, state MEM_WAIT 3 cycles then RUN, stall_cnt_o=4.
REQ-038 TIMEOUT=4, mem_ack_i never asserted -> ERROR after 4 MEM_WAIT cycles, err_o=1 held; late mem_ack_i=1 ignored; rst_i clears err_o.
REQ-039 Run 70000 stalled cycles -> stall_cnt_o stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - pipeline hazard, branch-flush and data-memory wait controller
//
// Decides each cycle whether the front end advances, bubbles or flushes, and
// freezes the back end while a data-memory access is outstanding. A memory
// access that is not acknowledged within TIMEOUT wait cycles parks the
// controller in a sticky error state that only reset leaves.
//
// Parameters:
//   TIMEOUT         maximum MEM_WAIT cycles before ERROR (1..255)
// Ports:
//   clk_i           clock, all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   IDEX_MemRead_i  instruction in EX is a load
//   IDEX_Rd_i       destination register of the instruction in EX
//   IFID_Rs1_i      rs1 of the instruction in ID
//   IFID_Rs2_i      rs2 of the instruction in ID
//   Branch_i        branch in ID resolved taken
//   MemAccess_i     instruction in MEM performs a load/store
//   mem_ack_i       data memory completes the access this cycle
//   PCWrite_o       PC update enable
//   IFID_Write_o    IF/ID update enable
//   NoOp_o          insert bubble into ID/EX
//   Flush_o         squash the instruction held in IF/ID
//   Stall_o         freeze ID/EX, EX/MEM and MEM/WB
//   mem_req_o       data-memory request strobe
//   err_o           sticky memory-timeout flag (registered)
//   stall_cnt_o     saturating count of cycles with PCWrite_o low (registered)

module pipeline_controller #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_Rd_i,
    input  logic [4:0]  IFID_Rs1_i,
    input  logic [4:0]  IFID_Rs2_i,
    input  logic        Branch_i,
    input  logic        MemAccess_i,
    input  logic        mem_ack_i,
    output logic        PCWrite_o,
    output logic        IFID_Write_o,
    output logic        NoOp_o,
    output logic        Flush_o,
    output logic        Stall_o,
    output logic        mem_req_o,
    output logic        err_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    // Wait-counter value on which an unacknowledged access gives up.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mem_stall;

    always_comb begin
        // A load writing x0 never creates a real dependency.
        load_use  = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                    ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));
        mem_stall = MemAccess_i && !mem_ack_i;

        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        PCWrite_o    = 1'b1;
        IFID_Write_o = 1'b1;
        NoOp_o       = 1'b0;
        Flush_o      = 1'b0;
        Stall_o      = 1'b0;
        mem_req_o    = 1'b0;

        if (rst_i) begin
            // Hold the front end and feed bubbles while reset is asserted.
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            NoOp_o       = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    mem_req_o = MemAccess_i;
                    if (mem_stall) begin
                        // Memory stall overrides load-use and branch handling;
                        // both get re-evaluated once the access completes.
                        Stall_o      = 1'b1;
                        PCWrite_o    = 1'b0;
                        IFID_Write_o = 1'b0;
                        state_d      = ST_MEM_WAIT;
                        wait_cnt_d   = 8'd0;
                    end else if (load_use) begin
                        // Bubble; a taken branch in ID is held until the
                        // hazard clears so its flush is not lost.
                        PCWrite_o    = 1'b0;
                        IFID_Write_o = 1'b0;
                        NoOp_o       = 1'b1;
                    end else if (Branch_i) begin
                        Flush_o = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    mem_req_o    = 1'b1;
                    Stall_o      = 1'b1;
                    PCWrite_o    = 1'b0;
                    IFID_Write_o = 1'b0;
                    if (mem_ack_i) begin
                        state_d    = ST_RUN;
                        wait_cnt_d = 8'd0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = ST_ERROR;
                        wait_cnt_d = 8'd0;
                        err_d      = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                ST_ERROR: begin
                    Stall_o      = 1'b1;
                    PCWrite_o    = 1'b0;
                    IFID_Write_o = 1'b0;
                    err_d        = 1'b1;
                end
                default: begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (!rst_i && !PCWrite_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - self-checking bench for pipeline_controller

module tb_pipeline_controller;

    localparam int unsigned TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        IDEX_MemRead_i;
    logic [4:0]  IDEX_Rd_i;
    logic [4:0]  IFID_Rs1_i;
    logic [4:0]  IFID_Rs2_i;
    logic        Branch_i;
    logic        MemAccess_i;
    logic        mem_ack_i;
    logic        PCWrite_o;
    logic        IFID_Write_o;
    logic        NoOp_o;
    logic        Flush_o;
    logic        Stall_o;
    logic        mem_req_o;
    logic        err_o;
    logic [15:0] stall_cnt_o;

    pipeline_controller #(.TIMEOUT(TMO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_Rd_i      (IDEX_Rd_i),
        .IFID_Rs1_i     (IFID_Rs1_i),
        .IFID_Rs2_i     (IFID_Rs2_i),
        .Branch_i       (Branch_i),
        .MemAccess_i    (MemAccess_i),
        .mem_ack_i      (mem_ack_i),
        .PCWrite_o      (PCWrite_o),
        .IFID_Write_o   (IFID_Write_o),
        .NoOp_o         (NoOp_o),
        .Flush_o        (Flush_o),
        .Stall_o        (Stall_o),
        .mem_req_o      (mem_req_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Output vectors are packed as {PCWrite, IFID_Write, NoOp, Flush, Stall, mem_req}.
    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       ma;
        logic       ack;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[14];

    int checks = 0;
    int errors = 0;

    // Reference model: "waiting" flag, number of wait cycles already spent,
    // sticky error flag and stall count.
    bit   m_wait;
    int   m_wc;
    bit   m_err;
    int   m_cnt;
    logic [5:0] act_outs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] model_outs();
        logic lu;
        lu = IDEX_MemRead_i && (IDEX_Rd_i != 0) &&
             (IDEX_Rd_i == IFID_Rs1_i || IDEX_Rd_i == IFID_Rs2_i);
        if (rst_i)                          return 6'b001000;
        if (m_err)                          return 6'b000010;
        if (m_wait)                         return 6'b000011;
        if (MemAccess_i && !mem_ack_i)      return 6'b000011;
        if (lu)                             return {5'b00100, MemAccess_i};
        return {3'b110, Branch_i, 1'b0, MemAccess_i};
    endfunction

    task automatic model_update();
        logic [5:0] e;
        e = model_outs();
        if (rst_i) begin
            m_wait = 0; m_wc = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (!e[5] && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_err) begin
            end else if (m_wait) begin
                m_wc = m_wc + 1;
                if (mem_ack_i) begin
                    m_wait = 0; m_wc = 0;
                end else if (m_wc == int'(TMO)) begin
                    m_err = 1; m_wait = 0; m_wc = 0;
                end
            end else if (MemAccess_i && !mem_ack_i) begin
                m_wait = 1; m_wc = 0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic br, input logic ma, input logic ack);
        rst_i = rst; IDEX_MemRead_i = mr; IDEX_Rd_i = rd;
        IFID_Rs1_i = r1; IFID_Rs2_i = r2;
        Branch_i = br; MemAccess_i = ma; mem_ack_i = ack;
        @(negedge clk_i);
        act_outs = {PCWrite_o, IFID_Write_o, NoOp_o, Flush_o, Stall_o, mem_req_o};
        chk("outs", 32'(act_outs), 32'(model_outs()));
        chk("err_o", 32'(err_o), 32'(m_err));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 6'b001000};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000};
        vecs[2]  = '{1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 6'b001000};
        vecs[3]  = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b0, 6'b001000};
        vecs[4]  = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000};
        vecs[5]  = '{1'b0, 1'b1, 5'd5, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 6'b110000};
        vecs[6]  = '{1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 6'b110000};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 6'b110100};
        vecs[8]  = '{1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 6'b001000};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 6'b110001};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b000011};
        vecs[11] = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 6'b000011};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 6'b110101};
        vecs[13] = '{1'b0, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 6'b001001};

        // Bring the DUT out of its unknown power-up state before any check.
        rst_i = 1; IDEX_MemRead_i = 0; IDEX_Rd_i = 0; IFID_Rs1_i = 0; IFID_Rs2_i = 0;
        Branch_i = 0; MemAccess_i = 0; mem_ack_i = 0;
        repeat (2) @(posedge clk_i);
        model_update();
        #1;

        // Table: each vector applied from a fresh reset.
        for (int i = 0; i < 14; i++) begin
            do_reset();
            step(vecs[i].rst, vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                 vecs[i].br, vecs[i].ma, vecs[i].ack);
            chk($sformatf("vec%0d", i), 32'(act_outs), 32'(vecs[i].exp));
        end

        // Load-use bubble bumps the stall count from 0 to 1.
        do_reset();
        chk("lu_cnt_before", 32'(stall_cnt_o), 32'd0);
        step(0, 1, 5, 0, 5, 0, 0, 0);
        chk("lu_outs", 32'(act_outs), 32'b001000);
        chk("lu_cnt_after", 32'(stall_cnt_o), 32'd1);

        // Branch held behind a load-use hazard, flushed the cycle after.
        do_reset();
        step(0, 1, 5, 5, 0, 1, 0, 0);
        chk("lu_br_hold", 32'(act_outs), 32'b001000);
        step(0, 0, 5, 5, 0, 1, 0, 0);
        chk("lu_br_flush", 32'(act_outs), 32'b110100);

        // Three-cycle memory wait then ack: four stalled cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, (i == 3));
            chk($sformatf("mw_stall%0d", i), 32'(act_outs), 32'b000011);
        end
        chk("mw_cnt", 32'(stall_cnt_o), 32'd4);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw_resume", 32'(act_outs), 32'b110000);

        // Timeout: TMO unacknowledged wait cycles then sticky error.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < int'(TMO); i++) begin
            chk($sformatf("tmo_err_low%0d", i), 32'(err_o), 32'd0);
            step(0, 0, 0, 0, 0, 0, 1, 0);
        end
        chk("tmo_err_set", 32'(err_o), 32'd1);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        chk("tmo_late_ack", 32'(act_outs), 32'b000010);
        chk("tmo_err_held", 32'(err_o), 32'd1);
        do_reset();
        chk("tmo_err_clr", 32'(err_o), 32'd0);

        // Reset in the middle of a memory wait abandons it.
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_wait_rst", 32'(act_outs), 32'b110000);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                 ($urandom_range(0, 9) < 6));
        end

        // Saturation: park in error and let the stall count run out.
        do_reset();
        for (int i = 0; i < int'(TMO) + 1; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk_i);
            model_update();
        end
        #1;
        chk("sat_cnt", 32'(stall_cnt_o), 32'hFFFF);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("sat_cnt_hold", 32'(stall_cnt_o), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
